cnn_bn_param_feeder: RTL and testbench

- Transmitter side of the batch-normalization parameter interface.
- Stores per-channel BN weight and bias words loaded once over a load port.
- Forwards a channel-major pixel stream with the matching channel's weight and bias attached, each with its own valid.
- Drives pxl_in/valid_in, weight_in/valid_weight_in and bias_in/valid_bias_in of the downstream batch-normalization block, cycle-aligned.

---
 rtl/cnn_bn_param_feeder.sv | 134 +++++++++++++
 tb/tb_cnn_bn_param_feeder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_bn_param_feeder.sv
// BN parameter feeder: loads per-channel weight/bias once, then tags a channel-major pixel stream with them.
// Optional BN_FEED_IDENTITY_EN: forward pixels in IDLE with weight=1.0, bias=0 before any load.
module cnn_bn_param_feeder #(
  parameter int DATA_WIDTH  = 32,
  parameter int CHANNEL_NUM = 16,
  parameter int IMAGE_SIZE  = 64
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_load_start,
  input  logic                  i_load_valid,
  input  logic [DATA_WIDTH-1:0] i_load_data,
  output logic                  o_param_ready,
  input  logic                  i_valid_in,
  input  logic [DATA_WIDTH-1:0] i_pxl_in,
  output logic                  o_valid_out,
  output logic [DATA_WIDTH-1:0] o_pxl_out,
  output logic                  o_valid_weight_out,
  output logic [DATA_WIDTH-1:0] o_weight_out,
  output logic                  o_valid_bias_out,
  output logic [DATA_WIDTH-1:0] o_bias_out,
  output logic                  o_frame_done
);
  localparam int LW = (2*CHANNEL_NUM > 1) ? $clog2(2*CHANNEL_NUM) : 1;
  localparam int CW = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
  localparam int PW = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
  localparam logic [DATA_WIDTH-1:0] ONE_F = DATA_WIDTH'(32'h3F80_0000);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  state_t                r_state;
  logic [LW-1:0]         r_load_cnt;
  logic [PW-1:0]         r_pix_cnt;
  logic [CW-1:0]         r_ch_cnt;
  logic                  r_vld;
  logic                  r_frame_done;
  logic [DATA_WIDTH-1:0] r_pxl, r_weight, r_bias;
  logic [DATA_WIDTH-1:0] r_wram [CHANNEL_NUM];
  logic [DATA_WIDTH-1:0] r_bram [CHANNEL_NUM];

  logic          w_we, w_in_bias, w_last_word, w_fwd, w_ident, w_pix_wrap, w_ch_wrap;
  logic [CW-1:0] w_waddr;

  always_comb begin
    w_we        = (r_state == S_LOAD) && i_load_valid && !i_load_start && !i_reset;
    w_in_bias   = r_load_cnt >= LW'(CHANNEL_NUM);
    w_waddr     = w_in_bias ? CW'(r_load_cnt - LW'(CHANNEL_NUM)) : CW'(r_load_cnt);
    w_last_word = r_load_cnt == LW'(2*CHANNEL_NUM-1);
    w_pix_wrap  = r_pix_cnt == PW'(IMAGE_SIZE-1);
    w_ch_wrap   = r_ch_cnt == CW'(CHANNEL_NUM-1);
    w_ident     = 1'b0;
`ifdef BN_FEED_IDENTITY_EN
    w_ident     = (r_state == S_IDLE);
    w_fwd       = i_valid_in && !i_load_start && ((r_state == S_RUN) || w_ident);
`else
    w_fwd       = i_valid_in && !i_load_start && (r_state == S_RUN);
`endif
  end

  // Parameter RAMs carry no reset; a reset simply forces a full reload before RUN.
  always_ff @(posedge i_clk) begin
    if (w_we) begin
      if (w_in_bias) r_bram[w_waddr] <= i_load_data;
      else           r_wram[w_waddr] <= i_load_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_load_cnt   <= '0;
      r_pix_cnt    <= '0;
      r_ch_cnt     <= '0;
      r_vld        <= 1'b0;
      r_frame_done <= 1'b0;
      r_pxl        <= '0;
      r_weight     <= '0;
      r_bias       <= '0;
    end else begin
      r_vld        <= w_fwd;
      r_frame_done <= w_fwd && w_pix_wrap && w_ch_wrap;
      if (w_fwd) begin
        r_pxl    <= i_pxl_in;
        r_weight <= w_ident ? ONE_F : r_wram[r_ch_cnt];
        r_bias   <= w_ident ? '0    : r_bram[r_ch_cnt];
        if (w_pix_wrap) begin
          r_pix_cnt <= '0;
          r_ch_cnt  <= w_ch_wrap ? '0 : r_ch_cnt + 1'b1;
        end else begin
          r_pix_cnt <= r_pix_cnt + 1'b1;
        end
      end
      // State transitions below take precedence over the counter advance above.
      case (r_state)
        S_IDLE: if (i_load_start) begin
          r_state    <= S_LOAD;
          r_load_cnt <= '0;
          r_pix_cnt  <= '0;
          r_ch_cnt   <= '0;
        end
        S_LOAD: begin
          if (i_load_start) begin
            r_load_cnt <= '0;
          end else if (i_load_valid) begin
            if (w_last_word) begin
              r_state    <= S_RUN;
              r_load_cnt <= '0;
              r_pix_cnt  <= '0;
              r_ch_cnt   <= '0;
            end else begin
              r_load_cnt <= r_load_cnt + 1'b1;
            end
          end
        end
        S_RUN: if (i_load_start) begin
          r_state    <= S_LOAD;
          r_load_cnt <= '0;
          r_pix_cnt  <= '0;
          r_ch_cnt   <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_param_ready      = (r_state == S_RUN);
  assign o_valid_out        = r_vld;
  assign o_valid_weight_out = r_vld;
  assign o_valid_bias_out   = r_vld;
  assign o_pxl_out          = r_pxl;
  assign o_weight_out       = r_weight;
  assign o_bias_out         = r_bias;
  assign o_frame_done       = r_frame_done;
endmodule

// File: tb/tb_cnn_bn_param_feeder.sv
// Scoreboard bench for cnn_bn_param_feeder with CHANNEL_NUM=2, IMAGE_SIZE=3.
module tb_cnn_bn_param_feeder;
  localparam int DW = 32;
  localparam int CH = 2;
  localparam int IS = 3;

  logic          clk = 1'b0;
  logic          reset, load_start, load_valid, valid_in;
  logic [DW-1:0] load_data, pxl_in;
  logic          param_ready, valid_out, valid_w, valid_b, frame_done;
  logic [DW-1:0] pxl_out, weight_out, bias_out;

  typedef struct {
    logic [DW-1:0] p;
    logic [DW-1:0] w;
    logic [DW-1:0] b;
    logic          fd;
  } exp_t;

  exp_t          q[$];
  int            checks = 0;
  int            failures = 0;
  logic [DW-1:0] m_w[CH];
  logic [DW-1:0] m_b[CH];
  int            m_pix = 0;
  int            m_ch = 0;

  cnn_bn_param_feeder #(.DATA_WIDTH(DW), .CHANNEL_NUM(CH), .IMAGE_SIZE(IS)) dut (
    .i_clk(clk), .i_reset(reset), .i_load_start(load_start), .i_load_valid(load_valid),
    .i_load_data(load_data), .o_param_ready(param_ready), .i_valid_in(valid_in),
    .i_pxl_in(pxl_in), .o_valid_out(valid_out), .o_pxl_out(pxl_out),
    .o_valid_weight_out(valid_w), .o_weight_out(weight_out), .o_valid_bias_out(valid_b),
    .o_bias_out(bias_out), .o_frame_done(frame_done));

  always #5 clk = ~clk;

  // Output monitor: every output cycle is matched against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (valid_w !== valid_out || valid_b !== valid_out) begin
        failures++;
        $display("FAIL valid_align: valid_out=%b valid_w=%b valid_b=%b, all must match", valid_out, valid_w, valid_b);
      end
      if (valid_out === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_out: pxl=%h w=%h b=%h with nothing expected", pxl_out, weight_out, bias_out);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (pxl_out !== e.p || weight_out !== e.w || bias_out !== e.b || frame_done !== e.fd) begin
            failures++;
            $display("FAIL out_data: got p=%h w=%h b=%h fd=%b, want p=%h w=%h b=%h fd=%b",
                     pxl_out, weight_out, bias_out, frame_done, e.p, e.w, e.b, e.fd);
          end
        end
      end else if (frame_done !== 1'b0) begin
        failures++;
        $display("FAIL frame_done_idle: frame_done=%b without valid_out, want 0", frame_done);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    load_start = 0; load_valid = 0; load_data = '0; valid_in = 0; pxl_in = '0;
  endtask

  // Expected output for a pixel accepted with current model parameters/counters.
  task automatic push_pixel(input logic [DW-1:0] p, input bit ident);
    exp_t e;
    e.p  = p;
    e.w  = ident ? 32'h3F80_0000 : m_w[m_ch];
    e.b  = ident ? 32'h0 : m_b[m_ch];
    e.fd = (m_pix == IS-1) && (m_ch == CH-1);
    q.push_back(e);
    if (m_pix == IS-1) begin
      m_pix = 0;
      m_ch  = (m_ch == CH-1) ? 0 : m_ch + 1;
    end else begin
      m_pix++;
    end
  endtask

  task automatic drain(input string name);
    clear_inputs();
    step();
    step();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: %0d outputs missing, want 0", name, q.size());
    end
    q.delete();
  endtask

  // Four load words (load_start assumed already given); checks ready timing.
  task automatic load_words(input string name, input logic [DW-1:0] w0, w1, b0, b1);
    logic [DW-1:0] wd[4];
    wd[0] = w0; wd[1] = w1; wd[2] = b0; wd[3] = b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (param_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s_ready_early: word %0d param_ready=%b want 0", name, i, param_ready);
      end
      load_start = 0; load_valid = 1; load_data = wd[i];
      step();
    end
    clear_inputs();
    checks++;
    if (param_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready: param_ready=%b want 1 after last word", name, param_ready);
    end
    m_w[0] = w0; m_w[1] = w1; m_b[0] = b0; m_b[1] = b1;
    m_pix = 0; m_ch = 0;
  endtask

  task automatic start_load();
    clear_inputs();
    load_start = 1;
    step();
    load_start = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    step();
    step();
    checks++;
    if ({param_ready, valid_out, valid_w, valid_b, frame_done} !== 5'b0 ||
        pxl_out !== '0 || weight_out !== '0 || bias_out !== '0) begin
      failures++;
      $display("FAIL reset_outputs: rdy=%b v=%b p=%h w=%h b=%h fd=%b, want all 0",
               param_ready, valid_out, pxl_out, weight_out, bias_out, frame_done);
    end
    reset = 0;
    step();
  endtask

  task automatic test_idle_input();
`ifdef BN_FEED_IDENTITY_EN
    valid_in = 1; pxl_in = 32'h4040_0000;
    push_pixel(32'h4040_0000, 1'b1);
    step();
    drain("identity");
`else
    valid_in = 1; pxl_in = 32'h4040_0000;
    step();
    drain("idle_ignored");
`endif
  endtask

  task automatic test_load();
    start_load();
    load_words("load", 32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 32'hBF80_0000);
  endtask

  task automatic test_continuous();
    for (int i = 1; i <= 6; i++) begin
      valid_in = 1; pxl_in = DW'(i);
      push_pixel(DW'(i), 1'b0);
      step();
    end
    drain("continuous");
  endtask

  task automatic test_gapped();
    for (int i = 0; i < 10; i++) begin
      valid_in = (i % 2 == 0);
      pxl_in   = DW'(32'h100 + i);
      if (valid_in) push_pixel(pxl_in, 1'b0);
      step();
    end
    drain("gapped");
  endtask

  task automatic test_back_to_back_wrap();
    for (int i = 0; i < 2*CH*IS + 1; i++) begin
      valid_in = 1; pxl_in = DW'($urandom);
      push_pixel(pxl_in, 1'b0);
      step();
    end
    drain("b2b");
  endtask

  task automatic test_reload_midframe();
    // Realign to a frame boundary so the two pixels sit mid-frame of channel 0.
    test_reset();
    start_load();
    load_words("preload", 32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 32'hBF80_0000);
    for (int i = 0; i < 2; i++) begin
      valid_in = 1; pxl_in = DW'(32'h200 + i);
      push_pixel(pxl_in, 1'b0);
      step();
    end
    valid_in = 1; pxl_in = 32'hDEAD_BEEF; load_start = 1;
    step();
    clear_inputs();
    checks++;
    if (param_ready !== 1'b0) begin
      failures++;
      $display("FAIL reload_ready: param_ready=%b want 0 after load_start", param_ready);
    end
    load_words("reload", 32'h4040_0000, 32'h4080_0000, 32'h3E80_0000, 32'hC000_0000);
    valid_in = 1; pxl_in = 32'h300;
    push_pixel(32'h300, 1'b0);
    step();
    drain("reload");
  endtask

  task automatic test_reset_midload();
    start_load();
    for (int i = 0; i < 2; i++) begin
      load_valid = 1; load_data = DW'(32'h1111_0000 + i);
      step();
    end
    clear_inputs();
    reset = 1;
    step();
    reset = 0;
    checks++;
    if (param_ready !== 1'b0 || valid_out !== 1'b0) begin
      failures++;
      $display("FAIL midload_reset: rdy=%b v=%b want 0/0", param_ready, valid_out);
    end
`ifndef BN_FEED_IDENTITY_EN
    valid_in = 1; pxl_in = 32'h400;
    step();
    drain("midload_idle");
`endif
    start_load();
    load_words("midload_full", 32'h4100_0000, 32'h4110_0000, 32'h4120_0000, 32'h4130_0000);
    for (int i = 0; i < IS + 1; i++) begin
      valid_in = 1; pxl_in = DW'(32'h500 + i);
      push_pixel(pxl_in, 1'b0);
      step();
    end
    drain("midload_run");
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    test_reset();
    test_idle_input();
    test_load();
    test_continuous();
    test_gapped();
    test_back_to_back_wrap();
    test_reload_midframe();
    test_reset_midload();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
